// File: rtl/uart_rx_if.sv
// Byte-side bus of the UART receiver: received byte, its strobe, error flags
// and the busy indicator. The receiver drives it (master) and the byte
// consumer observes it (slave).
//
// Handshake: rx_valid is a one-cycle strobe with no ready/back-pressure.
// rx_data, rx_frame_err and rx_parity_err are qualified by rx_valid in that
// cycle. The consumer must take the byte then, or read rx_data before the
// next frame completes. rx_busy is informational only.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_parity_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_frame_err,
    input rx_parity_err,
    input rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver. Samples the asynchronous serial line at mid-bit and
// deserialises one frame, LSB first, presenting the byte with a one-cycle
// valid strobe plus framing/parity error flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   undefined : 8N1 frames, rx_parity_err tied 0
//   defined   : 8E1 frames (even parity bit between data and stop)
//
// state_dbg exposes the FSM state encoding for observation:
//   0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 WAIT_HIGH
module uart_rx #(
  parameter int BAUD = 100_000,
  parameter int FCLK = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  uart_rx_if.master  rx_bus,
  output logic [2:0] state_dbg
);

  localparam int BIT  = FCLK / BAUD;
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT);

  localparam logic [CW-1:0] BIT_LD  = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
`ifdef UART_RX_PARITY_EN
    , S_PARITY  = 3'd3
`endif
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic          wc_zero;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic          par_bit;
  logic          parity_err_q;
`endif

  assign wc_zero = (cnt == '0);

  // Two-flop synchroniser for the asynchronous line; resets to idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with width counter, bit counter, shifter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      // Width counter runs down and parks at zero unless reloaded below.
      if (!wc_zero) cnt <= cnt - 1'b1;

      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          if (!rx_s) begin
            cnt   <= HALF_LD;
            state <= S_START;
          end
        end

        S_START: begin
          if (wc_zero) begin
            if (!rx_s) begin
              cnt   <= BIT_LD;
              state <= S_DATA;
            end else begin
              // Line went high again before mid-start: treat as a glitch.
              state <= S_IDLE;
            end
          end
        end

        S_DATA: begin
          if (wc_zero) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= BIT_LD;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (wc_zero) begin
            par_bit <= rx_s;
            cnt     <= BIT_LD;
            state   <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (wc_zero) begin
            data_q      <= shreg;
            valid_q     <= 1'b1;
            frame_err_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= ^{shreg, par_bit};
`endif
            // A low stop bit may be a break; wait for the line to recover.
            state <= rx_s ? S_IDLE : S_WAIT_HIGH;
          end
        end

        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx_bus.rx_data      = data_q;
  assign rx_bus.rx_valid     = valid_q;
  assign rx_bus.rx_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign rx_bus.rx_parity_err = parity_err_q;
`else
  assign rx_bus.rx_parity_err = 1'b0;
`endif
  assign rx_bus.rx_busy = (state != S_IDLE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. Runs at a faster line rate than the default so the
// whole sequence stays short; all timing is expressed in BIT/HALF.
module tb_uart_rx;

  localparam int BAUD   = 500_000;
  localparam int FCLK   = 50_000_000;
  localparam int BIT    = FCLK / BAUD;   // 100
  localparam int HALF   = BIT / 2;       // 50
  localparam int GLITCH = HALF - 10;     // low pulse shorter than half a bit

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [2:0] state_dbg;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if bus ();

  uart_rx #(.BAUD(BAUD), .FCLK(FCLK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_bus    (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  // entry = {parity_err, frame_err, data}
  logic [9:0] exp_q[$];
  int         vt[$];
  int         total = 0;
  int         bad = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic fe, input logic bad_par);
    logic pe;
`ifdef UART_RX_PARITY_EN
    pe = bad_par;
`else
    pe = 1'b0;
`endif
    exp_q.push_back({pe, fe, d});
  endtask

  // Monitor: pop and compare on every valid strobe.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      vt.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, e[7:0]});
        check("rx_frame_err", {31'd0, bus.rx_frame_err}, {31'd0, e[8]});
        check("rx_parity_err", {31'd0, bus.rx_parity_err}, {31'd0, e[9]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // One frame; par_flip inverts the even parity bit (parity build only).
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ par_flip, BIT);
`else
    if (par_flip) hold(1'b1, 0);
`endif
    hold(stop_v, BIT);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {24'd0, bus.rx_data}, 32'h00);
    check({tag, "_valid"}, {31'd0, bus.rx_valid}, 32'd0);
    check({tag, "_ferr"}, {31'd0, bus.rx_frame_err}, 32'd0);
    check({tag, "_perr"}, {31'd0, bus.rx_parity_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.rx_busy}, 32'd0);
    check({tag, "_state"}, {29'd0, state_dbg}, 32'd0);
  endtask

  // Watchdog: the sequence is bounded, this only guards against a hang.
  initial begin
    #(200_000 * 10);
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, BIT);

    // Basic frame.
    expect_byte(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    hold(1'b1, 5);
    check("a5_busy_after", {31'd0, bus.rx_busy}, 32'd0);
    check("a5_drained", exp_q.size(), 32'd0);

    // Short low glitch must be rejected.
    hold(1'b0, GLITCH);
    hold(1'b1, BIT);
    check("glitch_busy", {31'd0, bus.rx_busy}, 32'd0);
    check("glitch_state", {29'd0, state_dbg}, 32'd0);
    expect_byte(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold(1'b1, BIT);

    // Low stop bit followed by a held-low line (break).
    expect_byte(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 20 * BIT);
    check("break_state", {29'd0, state_dbg}, 32'd5);
    check("break_busy", {31'd0, bus.rx_busy}, 32'd1);
    hold(1'b1, 2 * BIT);
    check("break_recovered", {29'd0, state_dbg}, 32'd0);
    expect_byte(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    hold(1'b1, BIT);

    // Back-to-back frames, no idle gap.
    expect_byte(8'h00, 1'b0, 1'b0);
    expect_byte(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    hold(1'b1, BIT);
    if (vt.size() >= 2) begin
      int dt;
      dt = vt[vt.size()-1] - vt[vt.size()-2];
      check("b2b_spacing_ok", {31'd0, (dt >= 10*BIT-1) && (dt <= 10*BIT+1)}, 32'd1);
    end else begin
      check("b2b_valid_count", vt.size(), 32'd2);
    end
    check("ff_held", {24'd0, bus.rx_data}, 32'hFF);

    // Reset in the middle of data bit 4: partial byte discarded.
    hold(1'b0, BIT);
    hold(1'b1, BIT); hold(1'b0, BIT); hold(1'b1, BIT); hold(1'b1, BIT);
    hold(1'b0, HALF);
    check("midframe_busy", {31'd0, bus.rx_busy}, 32'd1);
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 2 * BIT);
    check("after_rst_data", {24'd0, bus.rx_data}, 32'h00);
    expect_byte(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    hold(1'b1, BIT);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 1 is correct, 0 is an error.
    expect_byte(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, BIT);
    expect_byte(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, BIT);
`endif

    // Every expected byte must have been seen.
    hold(1'b1, 2 * BIT);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
